// File: rtl/diff_io_pkg.sv
// rtl/diff_io_pkg.sv - pattern modes, buffer defaults and pattern init helper
package diff_io_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_WALK   = 2'd2,
      MODE_COUNT  = 2'd3
   } pat_mode_e;

   localparam DEFAULT_IOSTANDARD = "DIFF_SSTL135";
   localparam DEFAULT_SLEW       = "FAST";
   localparam int MAX_NCH        = 16;

   function automatic logic [MAX_NCH-1:0] pat_init(input pat_mode_e mode,
                                                   input logic [MAX_NCH-1:0] sw,
                                                   input int nch);
      logic [MAX_NCH-1:0] mask;
      mask = (nch >= MAX_NCH) ? '1 : MAX_NCH'((32'd1 << nch) - 32'd1);
      case (mode)
         MODE_STATIC: pat_init = sw & mask;
         MODE_WALK:   pat_init = MAX_NCH'(1);
         default:     pat_init = '0;
      endcase
   endfunction

endpackage

// File: rtl/diff_io_prims.sv
// rtl/diff_io_prims.sv - behavioural stand-ins for the vendor differential output buffers
module OBUFDS #(
   parameter IOSTANDARD = "DEFAULT",
   parameter SLEW       = "SLOW"
) (
   output wire O,
   output wire OB,
   input  wire I
);
   assign O  = I;
   assign OB = ~I;
endmodule

module OBUFTDS #(
   parameter IOSTANDARD = "DEFAULT",
   parameter SLEW       = "SLOW"
) (
   output wire O,
   output wire OB,
   input  wire I,
   input  wire T
);
   assign O  = T ? 1'bz : I;
   assign OB = T ? 1'bz : ~I;
endmodule

// File: rtl/diff_out_lane.sv
// rtl/diff_out_lane.sv - one differential output channel; OBUFTDS when DIFF_OUT_TRISTATE_EN, else OBUFDS
module diff_out_lane
   import diff_io_pkg::*;
#(
   parameter IOSTANDARD = DEFAULT_IOSTANDARD,
   parameter SLEW       = DEFAULT_SLEW
) (
   input  logic i,
   input  logic t,
   output wire  o,
   output wire  ob
);

`ifdef DIFF_OUT_TRISTATE_EN
   OBUFTDS #(
      .IOSTANDARD(IOSTANDARD),
      .SLEW      (SLEW)
   ) u_buf (
      .O (o),
      .OB(ob),
      .I (i),
      .T (t)
   );
`else
   // Always-driven lane: the tristate control is accepted but has no effect.
   logic t_unused;
   assign t_unused = t;

   OBUFDS #(
      .IOSTANDARD(IOSTANDARD),
      .SLEW      (SLEW)
   ) u_buf (
      .O (o),
      .OB(ob),
      .I (i)
   );
`endif

endmodule

// File: rtl/obufds_pattern_gen.sv
// rtl/obufds_pattern_gen.sv - multi-channel diff-pair pattern generator; DIFF_OUT_TRISTATE_EN adds oe
module obufds_pattern_gen
   import diff_io_pkg::*;
#(
   parameter int             NCH        = 4,
   parameter int             DIV_W      = 24,
   parameter logic [DIV_W-1:0] DIV_MAX  = DIV_W'(9_999_999),
   parameter                 IOSTANDARD = DEFAULT_IOSTANDARD,
   parameter                 SLEW       = DEFAULT_SLEW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] sw,
   input  logic [1:0]     mode,
`ifdef DIFF_OUT_TRISTATE_EN
   input  logic [NCH-1:0] oe,
`endif
   output wire  [NCH-1:0] diff_p,
   output wire  [NCH-1:0] diff_n
);

   logic [NCH-1:0]     sw_m, sw_s;
   logic [1:0]         mode_m, mode_s;
   pat_mode_e          mode_q, mode_new;
   logic [DIV_W-1:0]   cnt;
   logic               tick;
   logic [NCH-1:0]     pat, pat_rot, pat_ld, t_lane;
   logic [MAX_NCH-1:0] sw_ext, init_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_m   <= '0;
         sw_s   <= '0;
         mode_m <= '0;
         mode_s <= '0;
      end else begin
         sw_m   <= sw;
         sw_s   <= sw_m;
         mode_m <= mode;
         mode_s <= mode_m;
      end
   end

   assign mode_new = pat_mode_e'(mode_s);
   assign tick     = (cnt == DIV_MAX);

   always_comb begin
      sw_ext           = '0;
      sw_ext[NCH-1:0]  = sw_s;
   end

   assign init_full = pat_init(mode_new, sw_ext, NCH);
   assign pat_ld    = init_full[NCH-1:0];

   generate
      if (NCH < MAX_NCH) begin : g_init_spare
         logic [MAX_NCH-NCH-1:0] init_spare_unused;
         assign init_spare_unused = init_full[MAX_NCH-1:NCH];
      end
      // A single channel has nothing to walk into, so the lit bit stays put.
      if (NCH == 1) begin : g_rot_one
         assign pat_rot = pat;
      end else begin : g_rot_n
         assign pat_rot = {pat[NCH-2:0], pat[NCH-1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         pat    <= '0;
         mode_q <= MODE_STATIC;
      end else begin
         mode_q <= mode_new;
         if (mode_new != mode_q) begin
            // A mode change restarts the tick period and takes priority over any tick.
            cnt <= '0;
            pat <= pat_ld;
         end else begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            case (mode_q)
               MODE_STATIC: pat <= sw_s;
               MODE_BLINK:  if (tick) pat <= ~pat;
               MODE_WALK:   if (tick) pat <= pat_rot;
               MODE_COUNT:  if (tick) pat <= pat + NCH'(1);
               default:     pat <= pat;
            endcase
         end
      end
   end

`ifdef DIFF_OUT_TRISTATE_EN
   logic [NCH-1:0] oe_m, oe_s, t_q;

   // The extra t_q stage gives oe the same 3-cycle latency to the pads as sw.
   always_ff @(posedge clk) begin
      if (rst) begin
         oe_m <= '0;
         oe_s <= '0;
         t_q  <= '1;
      end else begin
         oe_m <= oe;
         oe_s <= oe_m;
         t_q  <= ~oe_s;
      end
   end

   assign t_lane = t_q;
`else
   assign t_lane = '0;
`endif

   generate
      for (genvar g = 0; g < NCH; g++) begin : g_lane
         diff_out_lane #(
            .IOSTANDARD(IOSTANDARD),
            .SLEW      (SLEW)
         ) u_lane (
            .i (pat[g]),
            .t (t_lane[g]),
            .o (diff_p[g]),
            .ob(diff_n[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_obufds_pattern_gen.sv
// tb/tb_obufds_pattern_gen.sv - scoreboard bench for obufds_pattern_gen (NCH=4, tick every 4 clk)
module tb_obufds_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic [1:0] mode;
   wire  [3:0] diff_p, diff_n;
`ifdef DIFF_OUT_TRISTATE_EN
   logic [3:0] oe;
`endif

   always #5 clk = ~clk;

   obufds_pattern_gen #(
      .NCH    (4),
      .DIV_W  (24),
      .DIV_MAX(24'd3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw),
      .mode  (mode),
`ifdef DIFF_OUT_TRISTATE_EN
      .oe    (oe),
`endif
      .diff_p(diff_p),
      .diff_n(diff_n)
   );

   typedef struct {
      int         due;
      logic [3:0] p;
      logic [3:0] n;
      string      nm;
   } exp_t;

   typedef struct {
      logic [1:0] md;
      logic [3:0] seq [5];
   } mode_vec_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   compl_chk = 1'b0;

   task automatic expect_pn(input int dly, input logic [3:0] p, input logic [3:0] n, input string nm);
      exp_t e;
      e.due = cyc + dly;
      e.p   = p;
      e.n   = n;
      e.nm  = nm;
      sbq.push_back(e);
   endtask

   task automatic expect_p(input int dly, input logic [3:0] p, input string nm);
      expect_pn(dly, p, ~p, nm);
   endtask

   // Sample one time unit after each active edge; retire every expectation due now.
   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].due == cyc) begin
            checks++;
            if (sbq[i].p !== diff_p || sbq[i].n !== diff_n) begin
               errors++;
               $display("FAIL %s cyc %0d: got p=%b n=%b want p=%b n=%b",
                        sbq[i].nm, cyc, diff_p, diff_n, sbq[i].p, sbq[i].n);
            end
            sbq.delete(i);
         end
      end
      if (compl_chk) begin
         checks++;
         if (diff_n !== ~diff_p) begin
            errors++;
            $display("FAIL compl cyc %0d: got p=%b n=%b want n=%b", cyc, diff_p, diff_n, ~diff_p);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [3:0] static_tab [4];
   mode_vec_t  mode_tab [3];
   logic [3:0] prev;

   initial begin
      static_tab = '{4'b0110, 4'b1111, 4'b0000, 4'b1001};
      mode_tab[0].md = 2'd1; mode_tab[0].seq = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
      mode_tab[1].md = 2'd2; mode_tab[1].seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      mode_tab[2].md = 2'd3; mode_tab[2].seq = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};

      rst  = 1'b1;
      sw   = 4'b1010;
      mode = 2'd0;
`ifdef DIFF_OUT_TRISTATE_EN
      oe   = 4'hF;
`endif
      // Reset and STATIC path latency
      wait_clk(2);
`ifdef DIFF_OUT_TRISTATE_EN
      expect_pn(1, 4'bzzzz, 4'bzzzz, "in_reset");
`else
      expect_p(1, 4'h0, "in_reset");
`endif
      wait_clk(1);
      rst = 1'b0;
`ifndef DIFF_OUT_TRISTATE_EN
      expect_p(1, 4'h0, "rel_plus1");
      expect_p(2, 4'h0, "rel_plus2");
`endif
      expect_p(3, 4'b1010, "rel_plus3");
      wait_clk(3);

      prev = 4'b1010;
      for (int v = 0; v < 4; v++) begin
         sw = static_tab[v];
         expect_p(2, prev, "static_hold");
         expect_p(3, static_tab[v], "static_new");
         prev = static_tab[v];
         wait_clk(3);
      end

      // BLINK / WALK / COUNT: init on change, then one step per 4 clk
      for (int v = 0; v < 3; v++) begin
         mode = mode_tab[v].md;
         expect_p(3, mode_tab[v].seq[0], "mode_init");
         for (int k = 1; k < 5; k++) begin
            expect_p(3 + 4 * k - 1, mode_tab[v].seq[k-1], "mode_hold");
            expect_p(3 + 4 * k, mode_tab[v].seq[k], "mode_step");
         end
         wait_clk(3 + 16);
      end

      // COUNT through a full wrap: 17 ticks end at 1
      mode = 2'd0;
      wait_clk(4);
      mode = 2'd3;
      compl_chk = 1'b1;
      expect_p(3, 4'h0, "count_init");
      for (int k = 1; k <= 17; k++) begin
         expect_p(3 + 4 * k - 1, 4'((k - 1) % 16), "count_hold");
         expect_p(3 + 4 * k, 4'(k % 16), "count_step");
      end
      wait_clk(3 + 68);
      compl_chk = 1'b0;

      // Mode change detected on the same edge as a tick: init wins
      wait_clk(1);
      mode = 2'd2;
      expect_p(3, 4'b0001, "chg_vs_tick");
      expect_p(6, 4'b0001, "chg_hold");
      expect_p(7, 4'b0010, "chg_cnt_restart");
      wait_clk(7);

      // Reset in the middle of COUNT at pat=7
      mode = 2'd3;
      expect_p(3, 4'h0, "count2_init");
      expect_p(31, 4'h7, "count2_at7");
      expect_p(32, 4'h7, "count2_at7_hold");
      wait_clk(32);
      rst = 1'b1;
`ifdef DIFF_OUT_TRISTATE_EN
      expect_pn(1, 4'bzzzz, 4'bzzzz, "rst_mid");
`else
      expect_p(1, 4'h0, "rst_mid");
`endif
      wait_clk(1);
      rst = 1'b0;
`ifndef DIFF_OUT_TRISTATE_EN
      expect_p(1, 4'h0, "post_rst1");
      expect_p(2, 4'h0, "post_rst2");
`endif
      expect_p(3, 4'h0, "post_rst_init");
      expect_p(6, 4'h0, "post_rst_hold");
      expect_p(7, 4'h1, "post_rst_tick");
      wait_clk(8);

      // Back to STATIC, then output-enable behaviour where present
      sw   = 4'b0110;
      mode = 2'd0;
      expect_p(3, 4'b0110, "static_return");
      wait_clk(4);
`ifdef DIFF_OUT_TRISTATE_EN
      oe = 4'b0000;
      expect_p(2, 4'b0110, "oe_off_hold");
      expect_pn(3, 4'bzzzz, 4'bzzzz, "oe_off");
      wait_clk(4);
      oe = 4'b0011;
      expect_pn(2, 4'bzzzz, 4'bzzzz, "oe_on_hold");
      expect_pn(3, 4'bzz10, 4'bzz01, "oe_partial");
      wait_clk(4);
`endif

      for (int i = 0; i < 200 && sbq.size() > 0; i++) wait_clk(1);
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending want 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
